// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the nibble-serial CLA adder sequencer.
package cla_seq_pkg;
  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Nibble index needs at least one bit even when there is a single nibble.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction
endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice: P/G generation plus c1..c4 lookahead; purely combinational.
// c3 is exported so the sequencer can form signed overflow on the top nibble.
module cla4_slice
  import cla_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_s,
  output logic                o_c4,
  output logic                o_c3
);
  logic [NIBBLE_W-1:0] w_p;
  logic [NIBBLE_W-1:0] w_g;
  logic [NIBBLE_W:0]   w_c;

  assign w_p    = i_a ^ i_b;
  assign w_g    = i_a & i_b;
  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_s  = w_p ^ w_c[NIBBLE_W-1:0];
  assign o_c4 = w_c[4];
  assign o_c3 = w_c[3];
endmodule

// File: rtl/cla_chain_sequencer.sv
// Wide adder reusing one 4-bit CLA slice LSB nibble first; done pulses WIDTH/4+1 cycles after accept.
// start is ignored (not queued) while busy; optional signed-overflow output under CLA_SEQ_OVF_EN.
module cla_chain_sequencer
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_SEQ_OVF_EN
  ,output logic            ovf
`endif
);
  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e r_state;
  state_e w_state_nxt;

  logic [WIDTH-1:0]    r_op_a;
  logic [WIDTH-1:0]    r_op_b;
  logic [WIDTH-1:0]    r_sum;
  logic                r_carry;
  logic                r_cout;
  logic [IDX_W-1:0]    r_idx;
  logic                w_accept;
  logic                w_last;
  logic [NIBBLE_W-1:0] w_s;
  logic                w_c4;
  logic                w_c3;

  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_idx == LAST_IDX);

  cla4_slice u_slice (
    .i_a   (r_op_a[{r_idx, 2'b00} +: NIBBLE_W]),
    .i_b   (r_op_b[{r_idx, 2'b00} +: NIBBLE_W]),
    .i_cin (r_carry),
    .o_s   (w_s),
    .o_c4  (w_c4),
    .o_c3  (w_c3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_op_a  <= a;
      r_op_b  <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[{r_idx, 2'b00} +: NIBBLE_W] <= w_s;
      r_carry <= w_c4;
      r_idx   <= r_idx + 1'b1;
      if (w_last) r_cout <= w_c4;
    end
  end

`ifdef CLA_SEQ_OVF_EN
  logic r_ovf;

  // Overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_ovf <= 1'b0;
    else if (w_accept)                   r_ovf <= 1'b0;
    else if ((r_state == RUN) && w_last) r_ovf <= w_c3 ^ w_c4;
  end

  assign ovf = r_ovf;
`else
  logic w_unused_c3;
  assign w_unused_c3 = w_c3;
`endif

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_cla_chain_sequencer.sv
// Directed bench for cla_chain_sequencer: WIDTH=16 vector table plus multi-cycle corner cases,
// and an exhaustive WIDTH=4 sweep on a second instance.
module tb_cla_chain_sequencer;
  localparam int NIB16 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, cin, busy, done, cout;
  logic [15:0] a, b, sum;
  logic        start4, cin4, busy4, done4, cout4;
  logic [3:0]  a4, b4, sum4;
`ifdef CLA_SEQ_OVF_EN
  logic        ovf, ovf4;
`endif

  int checks   = 0;
  int failures = 0;

  cla_chain_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef CLA_SEQ_OVF_EN
    ,.ovf(ovf)
`endif
  );

  cla_chain_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef CLA_SEQ_OVF_EN
    ,.ovf(ovf4)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_timing(input string nm, input int c);
    logic [1:0] exp;
    exp = {(c >= 1 && c <= NIB16), (c == NIB16 + 1)};
    chk($sformatf("%s busy_done c%0d", nm, c), {30'd0, busy, done}, {30'd0, exp});
  endtask

  task automatic chk_result(input string nm, input vec_t v);
    chk({nm, " sum"}, {16'd0, sum}, {16'd0, v.sum});
    chk({nm, " cout"}, {31'd0, cout}, {31'd0, v.cout});
`ifdef CLA_SEQ_OVF_EN
    chk({nm, " ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
`endif
  endtask

  task automatic launch(input vec_t v);
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    launch(v);
    for (int c = 1; c <= NIB16 + 1; c++) begin
      @(negedge clk);
      chk_timing(nm, c);
    end
    chk_result(nm, v);
  endtask

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    #12;
    chk("reset busy_done", {30'd0, busy, done}, 32'd0);
    chk("reset sum_cout", {15'd0, cout, sum}, 32'd0);
`ifdef CLA_SEQ_OVF_EN
    chk("reset ovf", {31'd0, ovf}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Start pulse mid-run with other operands must be dropped; result held afterwards.
    begin
      vec_t v1;
      v1 = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0};
      launch(v1);
      for (int c = 1; c <= 8; c++) begin
        @(negedge clk);
        if (c <= NIB16 + 1) chk_timing("ignore", c);
        else chk($sformatf("ignore idle c%0d", c), {30'd0, busy, done}, 32'd0);
        if (c == 2) begin start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; end
        if (c == 3) start = 1'b0;
        if (c >= NIB16 + 1) chk_result($sformatf("ignore c%0d", c), v1);
      end
    end

    // start held high: back-to-back ops every NIB+1 cycles; operands wiggle while busy.
    @(negedge clk);
    a = vecs[1].a; b = vecs[1].b; cin = vecs[1].cin; start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      for (int c = 1; c <= NIB16 + 1; c++) begin
        @(negedge clk);
        chk_timing($sformatf("hold%0d", k), c);
        if (c == 2) begin a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; end
        if (c == NIB16 + 1) begin
          chk_result($sformatf("hold%0d", k), vecs[(k % 2 == 0) ? 1 : 0]);
          a = vecs[(k % 2 == 0) ? 0 : 1].a;
          b = vecs[(k % 2 == 0) ? 0 : 1].b;
          cin = vecs[(k % 2 == 0) ? 0 : 1].cin;
          if (k == 3) start = 1'b0;
        end
      end
    end

    // Reset mid-run: outputs clear at once, no done, next op clean.
    run_vec("prerst", vecs[0]);
    begin
      vec_t v2;
      v2 = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0};
      launch(v2);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst busy_done", {30'd0, busy, done}, 32'd0);
      chk("midrst sum_cout", {15'd0, cout, sum}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        chk($sformatf("postrst idle c%0d", c), {30'd0, busy, done}, 32'd0);
      end
      run_vec("postrst", vecs[1]);
    end

    // Exhaustive single-nibble instance.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          logic [4:0] exp5;
          exp5 = 5'(ia) + 5'(ib) + 5'(ic);
          @(negedge clk);
          a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
          @(posedge clk);
          #1 start4 = 1'b0;
          @(negedge clk);
          chk($sformatf("w4 %0d+%0d+%0d c1", ia, ib, ic), {30'd0, busy4, done4}, 32'd2);
          @(negedge clk);
          chk($sformatf("w4 %0d+%0d+%0d c2", ia, ib, ic), {30'd0, busy4, done4}, 32'd1);
          chk($sformatf("w4 %0d+%0d+%0d res", ia, ib, ic), {27'd0, cout4, sum4}, {27'd0, exp5});
`ifdef CLA_SEQ_OVF_EN
          chk($sformatf("w4 %0d+%0d+%0d ovf", ia, ib, ic), {31'd0, ovf4},
              {31'd0, (a4[3] == b4[3]) && (exp5[3] != a4[3])});
`endif
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
